// File: rtl/move_buffer.sv
// move_buffer: first-word-fall-through circular FIFO of motion moves between SPI decoder and DDA executor
//   Parameters : DEPTH_BITS (log2 entry count), DATA_W (duration/increment/incinc width)
//   Clock/reset: clk, resetn (asynchronous, active-low)
//   Write side : wr_valid, wr_ready, wr_dir, wr_duration, wr_increment, wr_incinc
//   Read side  : rd_valid, rd_ready, rd_dir, rd_duration, rd_increment, rd_incinc
//   Status     : count (0..DEPTH), buffer_dtr (room for another move), overflow (sticky)
//   Option     : define MOVE_BUFFER_FLUSH_EN to add the synchronous flush input
module move_buffer #(
    parameter int DEPTH_BITS = 2,
    parameter int DATA_W     = 64
) (
    input  logic                  clk,
    input  logic                  resetn,
`ifdef MOVE_BUFFER_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic                  wr_dir,
    input  logic [DATA_W-1:0]     wr_duration,
    input  logic [DATA_W-1:0]     wr_increment,
    input  logic [DATA_W-1:0]     wr_incinc,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_dir,
    output logic [DATA_W-1:0]     rd_duration,
    output logic [DATA_W-1:0]     rd_increment,
    output logic [DATA_W-1:0]     rd_incinc,
    output logic [DEPTH_BITS:0]   count,
    output logic                  buffer_dtr,
    output logic                  overflow
);
    localparam int DEPTH = 1 << DEPTH_BITS;
    localparam int EW    = 3 * DATA_W + 1;

    logic [EW-1:0]       mem_q [DEPTH];
    logic [DEPTH_BITS:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic                overflow_q, overflow_d;
    logic                full, empty, wr_en, rd_en, flush_w;

`ifdef MOVE_BUFFER_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    // pointers carry one extra wrap bit so full and empty are distinguishable
    assign full  = (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]) &&
                   (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign wr_ready   = ~full;
    assign rd_valid   = ~empty;
    assign count      = wr_ptr_q - rd_ptr_q;
    assign buffer_dtr = ~full;
    assign overflow   = overflow_q;

    // wr_ready depends only on state, so a same-cycle read never frees a slot for the write
    assign wr_en = wr_valid & wr_ready & ~flush_w;
    assign rd_en = rd_valid & rd_ready & ~flush_w;

    always_comb begin
        wr_ptr_d   = flush_w ? '0 : wr_ptr_q + (DEPTH_BITS+1)'(wr_en);
        rd_ptr_d   = flush_w ? '0 : rd_ptr_q + (DEPTH_BITS+1)'(rd_en);
        overflow_d = flush_w ? 1'b0 : (overflow_q | (wr_valid & ~wr_ready));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // storage is not reset; the empty gate below keeps rd_* defined after reset
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[DEPTH_BITS-1:0]] <= {wr_dir, wr_duration, wr_increment, wr_incinc};
    end

    assign {rd_dir, rd_duration, rd_increment, rd_incinc} =
        rd_valid ? mem_q[rd_ptr_q[DEPTH_BITS-1:0]] : '0;
endmodule

// File: tb/tb_move_buffer.sv
// tb_move_buffer: directed bench for move_buffer with a queue-based reference model
module tb_move_buffer;
    localparam int DB = 2;
    localparam int DW = 64;
    localparam int DEPTH = 1 << DB;

    typedef struct packed {
        logic          dir;
        logic [DW-1:0] dur;
        logic [DW-1:0] inc;
        logic [DW-1:0] ii;
    } ent_t;

    logic clk = 0, resetn = 0;
    logic wr_valid = 0, rd_ready = 0, wr_dir = 0;
    logic [DW-1:0] wr_duration = 0, wr_increment = 0, wr_incinc = 0;
    logic wr_ready, rd_valid, rd_dir, buffer_dtr, overflow;
    logic [DW-1:0] rd_duration, rd_increment, rd_incinc;
    logic [DB:0] count;

    int checks = 0, errors = 0;

    move_buffer #(.DEPTH_BITS(DB), .DATA_W(DW)) dut (
        .clk(clk), .resetn(resetn),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dir(wr_dir),
        .wr_duration(wr_duration), .wr_increment(wr_increment), .wr_incinc(wr_incinc),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_dir(rd_dir),
        .rd_duration(rd_duration), .rd_increment(rd_increment), .rd_incinc(rd_incinc),
        .count(count), .buffer_dtr(buffer_dtr), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: a plain queue of moves plus a sticky overflow bit
    ent_t mq[$];
    logic m_ovf = 0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mq.delete();
            m_ovf = 0;
        end else begin
            int n;
            n = mq.size();
            if (wr_valid && n == DEPTH) m_ovf = 1;
            if (rd_ready && n > 0) void'(mq.pop_front());
            if (wr_valid && n < DEPTH) mq.push_back({wr_dir, wr_duration, wr_increment, wr_incinc});
        end
    end

    always @(negedge clk) begin
        ent_t h;
        h = (mq.size() > 0) ? mq[0] : '0;
        chk("count", DW'(count), DW'(mq.size()));
        chk("rd_valid", DW'(rd_valid), DW'(mq.size() != 0));
        chk("wr_ready", DW'(wr_ready), DW'(mq.size() != DEPTH));
        chk("buffer_dtr", DW'(buffer_dtr), DW'(mq.size() < DEPTH));
        chk("overflow", DW'(overflow), DW'(m_ovf));
        chk("rd_dir", DW'(rd_dir), DW'(h.dir));
        chk("rd_duration", rd_duration, h.dur);
        chk("rd_increment", rd_increment, h.inc);
        chk("rd_incinc", rd_incinc, h.ii);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic put(input logic d, input logic [DW-1:0] du, input logic [DW-1:0] in, input logic [DW-1:0] ii);
        wr_valid = 1; wr_dir = d; wr_duration = du; wr_increment = in; wr_incinc = ii;
    endtask

    initial begin
        tick(); tick();
        resetn = 1;
        chk("rst_count", DW'(count), 0);
        chk("rst_rd_valid", DW'(rd_valid), 0);
        chk("rst_wr_ready", DW'(wr_ready), 1);
        chk("rst_dtr", DW'(buffer_dtr), 1);
        chk("rst_overflow", DW'(overflow), 0);

        // single move, visible the cycle after the write edge
        put(1, 100, 64'h10, '1);
        tick();
        wr_valid = 0;
        chk("one_valid", DW'(rd_valid), 1);
        chk("one_dir", DW'(rd_dir), 1);
        chk("one_dur", rd_duration, 100);
        chk("one_inc", rd_increment, 64'h10);
        chk("one_ii", rd_incinc, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("one_count", DW'(count), 1);
        rd_ready = 1; tick();
        chk("one_drained", DW'(count), 0);
        tick();
        rd_ready = 0;
        chk("empty_read_ignored", DW'(count), 0);

        // fill to full, then an overflowing write
        for (int i = 0; i < 4; i++) begin
            put(i[0], DW'(200 + i), DW'(-3 * i), DW'(i * 7));
            tick();
        end
        chk("full_count", DW'(count), 4);
        chk("full_wr_ready", DW'(wr_ready), 0);
        chk("full_dtr", DW'(buffer_dtr), 0);
        chk("full_no_ovf", DW'(overflow), 0);
        put(1, 999, 0, 0);
        tick();
        wr_valid = 0;
        chk("ovf_set", DW'(overflow), 1);
        chk("ovf_count", DW'(count), 4);

        // drain in write order
        rd_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_dur", rd_duration, DW'(200 + i));
            chk("drain_inc", rd_increment, DW'(-3 * i));
            tick();
        end
        rd_ready = 0;
        chk("drained_count", DW'(count), 0);
        chk("drained_valid", DW'(rd_valid), 0);

        // full with simultaneous read: write is dropped, not written through
        for (int i = 0; i < 4; i++) begin
            put(0, DW'(300 + i), 0, 0);
            tick();
        end
        put(0, 399, 0, 0); rd_ready = 1;
        tick();
        wr_valid = 0; rd_ready = 0;
        chk("full_rw_count", DW'(count), 3);
        chk("full_rw_head", rd_duration, 301);
        rd_ready = 1;
        for (int i = 1; i < 4; i++) begin
            chk("full_rw_order", rd_duration, DW'(300 + i));
            tick();
        end
        rd_ready = 0;
        chk("full_rw_empty", DW'(count), 0);

        // streaming at count=2 across pointer wrap
        put(0, 500, 0, 0); tick();
        put(1, 501, 0, 0); tick();
        rd_ready = 1;
        for (int i = 0; i < 10; i++) begin
            put(i[0], DW'(502 + i), DW'(i), '1);
            chk("stream_head", rd_duration, DW'(500 + i));
            tick();
            chk("stream_count", DW'(count), 2);
        end
        wr_valid = 0;
        tick(); tick();
        rd_ready = 0;
        chk("stream_empty", DW'(count), 0);

        // asynchronous reset between edges with 3 queued moves and overflow still set
        for (int i = 0; i < 3; i++) begin
            put(1, DW'(600 + i), 0, 0);
            tick();
        end
        wr_valid = 0;
        chk("pre_rst_count", DW'(count), 3);
        #1 resetn = 0;
        #1;
        chk("async_count", DW'(count), 0);
        chk("async_valid", DW'(rd_valid), 0);
        chk("async_ovf", DW'(overflow), 0);
        chk("async_rd_dur", rd_duration, 0);
        tick();
        resetn = 1;

        // first write after reset
        put(0, 700, 64'h5, 64'h6); tick();
        wr_valid = 0;
        chk("post_rst_count", DW'(count), 1);
        chk("post_rst_dur", rd_duration, 700);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/move_buffer.md
MOVE_BUFFER -- requirements
Module: move_buffer

Interface
REQ-001 SHALL have parameter DEPTH_BITS, default 2, log2 of entry count (DEPTH = 2**DEPTH_BITS).
REQ-002 SHALL have parameter DATA_W, default 64, width of the duration, increment and increment-increment fields.
REQ-003 clk  in  1  single system clock; all state updates on rising edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 wr_valid  in  1  producer (SPI command decoder) offers a complete move.
REQ-006 wr_ready  out  1  buffer can accept a move this cycle.
REQ-007 wr_dir  in  1  move direction bit.
REQ-008 wr_duration  in  DATA_W  move length in DDA ticks.
REQ-009 wr_increment  in  DATA_W  signed initial substep increment.
REQ-010 wr_incinc  in  DATA_W  signed per-tick increment change.
REQ-011 rd_valid  out  1  head entry is present on the rd_* outputs.
REQ-012 rd_ready  in  1  DDA executor consumes the head entry.
REQ-013 rd_dir, rd_duration, rd_increment, rd_incinc  out  1/DATA_W/DATA_W/DATA_W  head entry fields.
REQ-014 count  out  DEPTH_BITS+1  number of stored entries, 0..DEPTH.
REQ-015 buffer_dtr  out  1  high when count < DEPTH (host may send another move).
REQ-016 overflow  out  1  sticky flag: write attempted while full.

Function
REQ-017 SHALL be a circular FIFO of DEPTH entries of {dir, duration, increment, incinc}.
REQ-018 Write SHALL occur on a cycle with wr_valid & wr_ready; read SHALL occur on a cycle with rd_valid & rd_ready.
REQ-019 wr_ready SHALL equal (count != DEPTH); no write-through when full, even if a read occurs in the same cycle.
REQ-020 rd_valid SHALL equal (count != 0); rd_* SHALL show the head entry combinationally from storage (first-word-fall-through).
REQ-021 Latency: a move written at edge N SHALL assert rd_valid after edge N (visible in cycle N+1) when the buffer was empty.
REQ-022 Write and read pointers SHALL be DEPTH_BITS+1 wide with natural wrap; full = MSBs differ and LSBs equal, empty = pointers equal.
REQ-023 Simultaneous write and read (0 < count < DEPTH) SHALL leave count unchanged and advance both pointers.
REQ-024 A read while rd_valid=0 SHALL be ignored; no pointer or count change.
REQ-025 wr_valid & !wr_ready SHALL set overflow on the next edge; the offered move SHALL be dropped; overflow clears only on reset (or flush, REQ-030).
REQ-026 rd_* values while rd_valid=0 are don't-care but SHALL NOT be X after reset (storage outputs gated to 0 when empty).
REQ-027 Entries SHALL be delivered in write order with all fields bit-exact; signed fields are stored unmodified.

Reset
REQ-028 On resetn low, asynchronously: pointers=0, count=0, overflow=0, hence rd_valid=0, wr_ready=1, buffer_dtr=1; storage contents need not be cleared.
REQ-029 Reset mid-operation SHALL discard all queued moves; first write after release lands at index 0.

Configuration
REQ-030 With MOVE_BUFFER_FLUSH_EN defined, input port flush (1 bit, synchronous) SHALL be present; flush high at an edge SHALL set pointers and count to 0 and clear overflow, taking priority over a same-cycle write or read.
REQ-031 Without MOVE_BUFFER_FLUSH_EN, no flush port SHALL exist and only resetn empties the buffer.

Verification
REQ-032 Reset, write one move {dir=1, duration=100, inc=0x10, incinc=-1} -> rd_valid=1 next cycle, fields match, count=1.
REQ-033 Write 4 moves (DEPTH_BITS=2) with rd_ready=0 -> count=4, wr_ready=0, buffer_dtr=0; 5th wr_valid -> overflow=1, count stays 4.
REQ-034 Full buffer, drain with rd_ready=1 for 4 cycles -> entries emerge in write order, count reaches 0, rd_valid=0.
REQ-035 count=2, wr_valid=rd_ready=1 for 10 cycles -> count stays 2, pointers wrap, data order preserved.
REQ-036 count=3, assert resetn low asynchronously between edges -> count=0, rd_valid=0, overflow=0 immediately.
REQ-037 (MOVE_BUFFER_FLUSH_EN) count=3, overflow=1, flush with wr_valid=1 same cycle -> count=0, overflow=0, write discarded.
